conv_mac_sched: RTL and testbench

Sequencing controller for the 1-D convolution datapath: X buffer, F ROM, P parallel MAC lanes and the AXI-style output port.
- Starts once the X buffer reports full.
- Issues X/F read addresses for each group of P outputs, times multiply/accumulate enables through the datapath pipeline, then serialises the P lane results onto m_data_out_y with valid/ready.
- After the last output handshake, pulses conv_done so the X buffer and F address logic reset.

---
 rtl/conv_sched_pkg.sv | 31 +++
 rtl/conv_en_pipe.sv | 39 +++
 rtl/conv_mac_sched.sv | 155 +++++++++++++++
 tb/tb_conv_mac_sched.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/conv_sched_pkg.sv
// Shared types and sizing helpers for the 1-D convolution sequencing controller.
package conv_sched_pkg;

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      WAIT = 3'd2,
      OUT  = 3'd3,
      DONE = 3'd4
   } state_t;

   // Memory read latency and multiplier register latency in the datapath
   localparam int RD_LAT  = 1;
   localparam int MUL_LAT = 1;

   // Number of valid convolution outputs
   function automatic int calc_outs(input int n, input int m);
      return n - m + 1;
   endfunction

   // Number of P-wide output groups
   function automatic int calc_ng(input int outs, input int p);
      return (outs + p - 1) / p;
   endfunction

   // Lanes that carry real outputs in the group starting at output index g
   function automatic int lanes_in_group(input int p, input int outs, input int g);
      return ((outs - g) < p) ? (outs - g) : p;
   endfunction

endpackage

// File: rtl/conv_en_pipe.sv
// Delays the LOAD / first-tap flags so the MAC enables line up with read data.
import conv_sched_pkg::*;

module conv_en_pipe #(
   parameter int STAGES   = 2,
   parameter int MULT_TAP = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic load_p0,
   input  logic first_p0,
   output logic en_mult,
   output logic en_accum,
   output logic accum_first
);

   logic [STAGES-1:0] load_sr;
   logic [STAGES-1:0] first_sr;

   // Shift both flags one stage per clock; stage s holds the flag from s+1 cycles ago
   always_ff @(posedge clk) begin
      if (reset) begin
         load_sr  <= '0;
         first_sr <= '0;
      end else begin
         load_sr[0]  <= load_p0;
         first_sr[0] <= first_p0;
         for (int s = 1; s < STAGES; s++) begin
            load_sr[s]  <= load_sr[s-1];
            first_sr[s] <= first_sr[s-1];
         end
      end
   end

   assign en_mult     = load_sr[MULT_TAP-1];
   assign en_accum    = load_sr[STAGES-1];
   assign accum_first = first_sr[STAGES-1];

endmodule

// File: rtl/conv_mac_sched.sv
// Sequencing controller for the 1-D convolution datapath (X buffer, F ROM,
// P MAC lanes, valid/ready output port).
// Optional: define CONV_SCHED_STALL_CNT_EN to add the stall_cnt output.
import conv_sched_pkg::*;

module conv_mac_sched #(
   parameter int N   = 43,
   parameter int M   = 16,
   parameter int P   = 1,
   parameter int XAW = 6,
   parameter int FAW = 4,
   localparam int SELW = (P > 1) ? $clog2(P) : 1
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            conv_start,
   input  logic            m_ready_y,
   output logic [XAW-1:0]  xmem_addr_base,
   output logic [FAW-1:0]  fmem_addr,
   output logic            en_mult,
   output logic            en_accum,
   output logic            accum_first,
   output logic [SELW-1:0] out_sel,
   output logic            m_valid_y,
   output logic            conv_done
`ifdef CONV_SCHED_STALL_CNT_EN
   ,output logic [15:0]    stall_cnt
`endif
);

   localparam int OUTS = calc_outs(N, M);
   localparam int NG   = calc_ng(OUTS, P);
   localparam int GIW  = (NG > 1) ? $clog2(NG) : 1;

   state_t          state;
   logic [XAW-1:0]  grp;        // first output index of the current group
   logic [GIW-1:0]  grp_idx;    // group number, identifies the last group
   logic [FAW-1:0]  k;          // tap counter
   logic [SELW-1:0] lane;
   logic            wait_cnt;
   logic [SELW-1:0] last_lane;
   logic            last_grp;
   logic            start_go;
   logic            load_p0;
   logic            first_p0;

   assign last_lane = SELW'(lanes_in_group(P, OUTS, int'(grp)) - 1);
   assign last_grp  = (grp_idx == GIW'(NG - 1));
   // A start is taken in IDLE, and also in DONE so back-to-back runs re-enter
   // LOAD the cycle after conv_done without an idle bubble.
   assign start_go  = conv_start && ((state == IDLE) || (state == DONE));
   assign load_p0   = (state == LOAD);
   assign first_p0  = (state == LOAD) && (k == '0);

   // Output valid and lane mux are decoded from registers only
   assign m_valid_y = (state == OUT);
   assign out_sel   = (state == OUT) ? lane : '0;

   // Main sequencer: group/tap/lane counters, registered addresses and done pulse
   always_ff @(posedge clk) begin
      if (reset) begin
         state          <= IDLE;
         grp            <= '0;
         grp_idx        <= '0;
         k              <= '0;
         lane           <= '0;
         wait_cnt       <= 1'b0;
         xmem_addr_base <= '0;
         fmem_addr      <= '0;
         conv_done      <= 1'b0;
      end else begin
         conv_done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start_go) begin
                  state          <= LOAD;
                  grp            <= '0;
                  grp_idx        <= '0;
                  k              <= '0;
                  xmem_addr_base <= '0;
                  fmem_addr      <= '0;
               end else begin
                  state <= IDLE;
               end
            end
            LOAD: begin
               if (k == FAW'(M - 1)) begin
                  state    <= WAIT;
                  wait_cnt <= 1'b0;
               end else begin
                  k              <= k + FAW'(1);
                  xmem_addr_base <= grp + XAW'(k) + XAW'(1);
                  fmem_addr      <= k + FAW'(1);
               end
            end
            WAIT: begin
               if (wait_cnt) begin
                  state <= OUT;
                  lane  <= '0;
               end else begin
                  wait_cnt <= 1'b1;
               end
            end
            OUT: begin
               if (m_ready_y) begin
                  if (lane == last_lane) begin
                     lane <= '0;
                     if (!last_grp) begin
                        state          <= LOAD;
                        grp            <= grp + XAW'(P);
                        grp_idx        <= grp_idx + GIW'(1);
                        k              <= '0;
                        xmem_addr_base <= grp + XAW'(P);
                        fmem_addr      <= '0;
                     end else begin
                        state     <= DONE;
                        conv_done <= 1'b1;
                     end
                  end else begin
                     lane <= lane + SELW'(1);
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   conv_en_pipe #(
      .STAGES   (RD_LAT + MUL_LAT),
      .MULT_TAP (RD_LAT)
   ) u_en_pipe (
      .clk         (clk),
      .reset       (reset),
      .load_p0     (load_p0),
      .first_p0    (first_p0),
      .en_mult     (en_mult),
      .en_accum    (en_accum),
      .accum_first (accum_first)
   );

`ifdef CONV_SCHED_STALL_CNT_EN
   // Saturating count of back-pressured output cycles, cleared on a fresh start
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt <= '0;
      end else if (start_go) begin
         stall_cnt <= '0;
      end else if (m_valid_y && !m_ready_y && (stall_cnt != 16'hFFFF)) begin
         stall_cnt <= stall_cnt + 16'd1;
      end
   end
`endif

endmodule

// File: tb/tb_conv_mac_sched.sv
// Bench for conv_mac_sched: a P=1 and a P=3 instance share reset and ready.
module tb_conv_mac_sched;

   localparam int OUTS = 28;
   localparam int MM   = 16;

   typedef struct {
      int lane;
      int cyc;
   } hs_t;

   logic clk = 1'b0;
   logic reset = 1'b1;
   logic start1 = 1'b0;
   logic start3 = 1'b0;
   logic m_ready_y = 1'b1;

   logic [5:0] xa1, xa3;
   logic [3:0] fa1, fa3;
   logic       em1, ea1, af1, v1, d1;
   logic       em3, ea3, af3, v3, d3;
   logic       sel1;
   logic [1:0] sel3;
`ifdef CONV_SCHED_STALL_CNT_EN
   logic [15:0] st1, st3;
`endif

   int  nerr = 0;
   int  nchk = 0;
   int  cyc  = 0;
   int  pv [2] = '{1, 3};
   hs_t q [2][$];
   int  t0 [2];
   int  done_exp [2];
   int  done_cnt [2] = '{0, 0};
   bit  timed [2] = '{0, 0};
   bit  trace_on = 1'b0;

   logic       vld_a [2];
   logic       done_a [2];
   logic [1:0] sel_a [2];

   assign vld_a[0]  = v1;
   assign vld_a[1]  = v3;
   assign done_a[0] = d1;
   assign done_a[1] = d3;
   assign sel_a[0]  = {1'b0, sel1};
   assign sel_a[1]  = sel3;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   conv_mac_sched #(.N(43), .M(16), .P(1), .XAW(6), .FAW(4)) dut1 (
      .clk(clk), .reset(reset), .conv_start(start1), .m_ready_y(m_ready_y),
      .xmem_addr_base(xa1), .fmem_addr(fa1), .en_mult(em1), .en_accum(ea1),
      .accum_first(af1), .out_sel(sel1), .m_valid_y(v1), .conv_done(d1)
`ifdef CONV_SCHED_STALL_CNT_EN
      , .stall_cnt(st1)
`endif
   );

   conv_mac_sched #(.N(43), .M(16), .P(3), .XAW(6), .FAW(4)) dut3 (
      .clk(clk), .reset(reset), .conv_start(start3), .m_ready_y(m_ready_y),
      .xmem_addr_base(xa3), .fmem_addr(fa3), .en_mult(em3), .en_accum(ea3),
      .accum_first(af3), .out_sel(sel3), .m_valid_y(v3), .conv_done(d3)
`ifdef CONV_SCHED_STALL_CNT_EN
      , .stall_cnt(st3)
`endif
   );

   task automatic chk(input string tag, input int act, input int exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, act, exp, cyc);
      end
   endtask

   // Expected handshakes of one full run, lane order and cycle offsets
   task automatic push_run(input int i, input int t0v, input bit tm);
      int g, base, n;
      g = 0;
      base = 0;
      while (g < OUTS) begin
         n = (OUTS - g < pv[i]) ? (OUTS - g) : pv[i];
         for (int l = 0; l < n; l++) q[i].push_back('{l, base + MM + 2 + l});
         base += MM + 2 + n;
         g += pv[i];
      end
      done_exp[i] = base;
      t0[i] = t0v;
      timed[i] = tm;
   endtask

   // Called at posedge+1; the start is sampled at the next edge (cycle 0)
   task automatic start_run(input bit s1, input bit s3, input bit tm, input bit hold);
      if (s1) begin start1 = 1'b1; push_run(0, cyc + 1, tm); end
      if (s3) begin start3 = 1'b1; push_run(1, cyc + 1, tm); end
      @(posedge clk); #1;
      if (!hold) begin start1 = 1'b0; start3 = 1'b0; end
   endtask

   task automatic wait_runs(input int tg0, input int tg1, input int budget, input bit rnd);
      int n;
      n = 0;
      while ((done_cnt[0] < tg0 || done_cnt[1] < tg1) && n < budget) begin
         @(posedge clk); #1;
         if (rnd) m_ready_y = ($urandom_range(0, 3) != 0);
         n++;
      end
      m_ready_y = 1'b1;
      chk("run_complete", int'(done_cnt[0] >= tg0 && done_cnt[1] >= tg1), 1);
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_p1"}, int'({xa1, fa1, em1, ea1, af1, sel1, v1, d1}), 0);
      chk({tag, "_p3"}, int'({xa3, fa3, em3, ea3, af3, sel3, v3, d3}), 0);
   endtask

   // Scoreboard monitor: handshakes, done pulses and the G=5 address trace
   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         automatic int rel = cyc - t0[i];
         automatic hs_t e;
         if (vld_a[i] && m_ready_y) begin
            if (q[i].size() == 0) begin
               chk($sformatf("hs_unexpected_%0d", i), 1, 0);
            end else begin
               e = q[i].pop_front();
               chk($sformatf("out_sel_%0d", i), int'(sel_a[i]), e.lane);
               if (timed[i]) chk($sformatf("hs_cycle_%0d", i), rel, e.cyc);
            end
         end
         if (done_a[i]) begin
            done_cnt[i]++;
            chk($sformatf("done_pending_%0d", i), q[i].size(), 0);
            if (timed[i]) chk($sformatf("done_cycle_%0d", i), rel, done_exp[i]);
         end
      end
      if (trace_on) begin
         automatic int rel = cyc - t0[0];
         if (rel >= 95 && rel <= 110) begin
            chk("g5_xaddr", int'(xa1), 5 + rel - 95);
            chk("g5_faddr", int'(fa1), rel - 95);
         end
         if (rel >= 95 && rel <= 113) begin
            chk("g5_en_mult", int'(em1), int'(rel >= 96 && rel <= 111));
            chk("g5_en_accum", int'(ea1), int'(rel >= 97 && rel <= 112));
            chk("g5_accum_first", int'(af1), int'(rel == 97));
         end
      end
   end

   initial begin
      int dc0, dc1;
`ifdef CONV_SCHED_STALL_CNT_EN
      int s0;
`endif
      repeat (3) @(posedge clk);
      #1;
      chk_zero("reset_state");
      reset = 1'b0;
      @(posedge clk); #1;
      chk_zero("idle_state");

      // Free-running run on both instances, with the G=5 trace on P=1
      trace_on = 1'b1;
      start_run(1'b1, 1'b1, 1'b1, 1'b0);
      wait_runs(1, 1, 700, 1'b0);
      trace_on = 1'b0;
      repeat (3) @(posedge clk);
      #1;

      // Back-pressure held for 5 cycles mid-group on P=3, then random ready
      start_run(1'b1, 1'b1, 1'b0, 1'b0);
      begin
         int n;
         n = 0;
         while (!(v3 && sel3 == 2'd1) && n < 100) begin @(posedge clk); #1; n++; end
         chk("bp_reach_lane1", int'(v3 && sel3 == 2'd1), 1);
      end
`ifdef CONV_SCHED_STALL_CNT_EN
      s0 = int'(st3);
`endif
      m_ready_y = 1'b0;
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         chk("bp_valid_hold", int'(v3), 1);
         chk("bp_sel_hold", int'(sel3), 1);
      end
`ifdef CONV_SCHED_STALL_CNT_EN
      chk("stall_cnt_delta", int'(st3) - s0, 5);
`endif
      wait_runs(2, 2, 3000, 1'b1);
      repeat (3) @(posedge clk);
      #1;

      // Reset asserted during the 7th LOAD cycle abandons the run
      dc0 = done_cnt[0];
      dc1 = done_cnt[1];
      start_run(1'b1, 1'b1, 1'b0, 1'b0);
      repeat (6) @(posedge clk);
      #1;
      reset = 1'b1;
      @(posedge clk); #1;
      chk_zero("mid_load_reset");
      q[0].delete();
      q[1].delete();
      reset = 1'b0;
      repeat (30) @(posedge clk);
      #1;
      chk("no_done_after_reset_p1", done_cnt[0], dc0);
      chk("no_done_after_reset_p3", done_cnt[1], dc1);
      chk("idle_after_reset", int'({v1, v3}), 0);

      // Fresh start after reset runs from G=0 with nominal timing
      start_run(1'b1, 1'b1, 1'b1, 1'b0);
      wait_runs(dc0 + 1, dc1 + 1, 700, 1'b0);
      repeat (2) @(posedge clk);
      #1;

      // conv_start held high: the next run begins the cycle after conv_done
      start_run(1'b1, 1'b0, 1'b1, 1'b1);
      wait_runs(dc0 + 2, 0, 700, 1'b0);
      push_run(0, cyc, 1'b1);
      start1 = 1'b0;
      @(posedge clk); #1;
      chk("restart_en_mult", int'(em1), 1);
      wait_runs(dc0 + 3, 0, 700, 1'b0);
      repeat (25) @(posedge clk);
      #1;
      chk("no_extra_run", int'(v1), 0);
      chk("done_total_p1", done_cnt[0], 5);
      chk("done_total_p3", done_cnt[1], 3);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
